wb_port_arbiter: RTL and testbench

//  Shares the single register-file write port between the even and odd pipes
//  at the end of their MEM/WB stages.

---
 rtl/wb_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Merges the even and odd pipe write-backs onto the single register-file write port.
// Each pipe has a small FIFO; heads are arbitrated round-robin, with older-first ordering for same-register writes.
module wb_port_arbiter #(
    parameter int DATA_W  = 129,
    parameter int ADDR_W  = 7,
    parameter int DEPTH   = 2,
    parameter int STAMP_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              even_valid,
    output logic              even_ready,
    input  logic [ADDR_W-1:0] even_rt,
    input  logic [DATA_W-1:0] even_data,
    input  logic              odd_valid,
    output logic              odd_ready,
    input  logic [ADDR_W-1:0] odd_rt,
    input  logic [DATA_W-1:0] odd_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [2:0]        pending
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [STAMP_W-1:0] stamp;
        logic [ADDR_W-1:0]  rt;
        logic [DATA_W-1:0]  data;
    } entry_t;

    entry_t             r_even_mem [DEPTH];
    entry_t             r_odd_mem  [DEPTH];
    logic [PTR_W-1:0]   r_even_wp, r_even_rp, r_odd_wp, r_odd_rp;
    logic [CNT_W-1:0]   r_even_cnt, r_odd_cnt;
    logic [STAMP_W-1:0] r_stamp;
    logic               r_rr_odd;
    logic               r_even_ready, r_odd_ready;
    logic               r_we;
    logic [ADDR_W-1:0]  r_waddr;
    logic [DATA_W-1:0]  r_wdata;
    logic [2:0]         r_pending;

    entry_t             w_even_head, w_odd_head;
    logic               w_even_nonempty, w_odd_nonempty;
    logic               w_same_rt, w_even_older;
    logic [STAMP_W-1:0] w_stamp_diff;
    logic               w_grant_even, w_grant_odd, w_rr_flip;
    logic               w_even_push, w_odd_push;
    logic [CNT_W-1:0]   w_even_cnt_next, w_odd_cnt_next;
    logic [2:0]         w_pending_next;
    logic [ADDR_W-1:0]  w_grant_rt;
    logic [DATA_W-1:0]  w_grant_data;

    assign w_even_head     = r_even_mem[r_even_rp];
    assign w_odd_head      = r_odd_mem[r_odd_rp];
    assign w_even_nonempty = (r_even_cnt != '0);
    assign w_odd_nonempty  = (r_odd_cnt != '0);
    assign w_same_rt       = (w_even_head.rt == w_odd_head.rt);

    // Residence time stays far below half the stamp range, so the sign of the
    // modular difference tells which head was pushed first (zero means same edge).
    assign w_stamp_diff = w_odd_head.stamp - w_even_head.stamp;
    assign w_even_older = ~w_stamp_diff[STAMP_W-1];

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        w_grant_even = 1'b0;
        w_grant_odd  = 1'b0;
        w_rr_flip    = 1'b0;
        if (!flush) begin
            if (w_even_nonempty && w_odd_nonempty) begin
                if (w_same_rt) begin
                    w_grant_even = w_even_older;
                    w_grant_odd  = ~w_even_older;
                end else begin
                    w_grant_even = ~r_rr_odd;
                    w_grant_odd  = r_rr_odd;
                    w_rr_flip    = 1'b1;
                end
            end else begin
                w_grant_even = w_even_nonempty;
                w_grant_odd  = w_odd_nonempty;
            end
        end
    end

    assign w_grant_rt   = w_grant_odd ? w_odd_head.rt   : w_even_head.rt;
    assign w_grant_data = w_grant_odd ? w_odd_head.data : w_even_head.data;

    assign w_even_push = even_valid && r_even_ready && !flush;
    assign w_odd_push  = odd_valid  && r_odd_ready  && !flush;

    assign w_even_cnt_next = flush ? '0
                           : r_even_cnt + CNT_W'(w_even_push) - CNT_W'(w_grant_even);
    assign w_odd_cnt_next  = flush ? '0
                           : r_odd_cnt + CNT_W'(w_odd_push) - CNT_W'(w_grant_odd);
    assign w_pending_next  = 3'(w_even_cnt_next) + 3'(w_odd_cnt_next);

    // NOTE: FIFO storage has no reset; the counts alone define which entries are valid, so clearing the payload would be wasted flops.
    always_ff @(posedge clk) begin
        if (w_even_push) begin
            r_even_mem[r_even_wp] <= '{stamp: r_stamp, rt: even_rt, data: even_data};
        end
        if (w_odd_push) begin
            r_odd_mem[r_odd_wp] <= '{stamp: r_stamp, rt: odd_rt, data: odd_data};
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_even_wp    <= '0;
            r_even_rp    <= '0;
            r_odd_wp     <= '0;
            r_odd_rp     <= '0;
            r_even_cnt   <= '0;
            r_odd_cnt    <= '0;
            r_stamp      <= '0;
            r_rr_odd     <= 1'b0;
            r_even_ready <= 1'b0;
            r_odd_ready  <= 1'b0;
            r_we         <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
            r_pending    <= '0;
        end else begin
            r_stamp      <= r_stamp + STAMP_W'(1);
            r_even_cnt   <= w_even_cnt_next;
            r_odd_cnt    <= w_odd_cnt_next;
            r_even_ready <= (w_even_cnt_next < CNT_W'(DEPTH));
            r_odd_ready  <= (w_odd_cnt_next < CNT_W'(DEPTH));
            r_pending    <= w_pending_next;
            if (flush) begin
                r_even_wp <= '0;
                r_even_rp <= '0;
                r_odd_wp  <= '0;
                r_odd_rp  <= '0;
                r_we      <= 1'b0;
            end else begin
                if (w_even_push)  r_even_wp <= r_even_wp + PTR_W'(1);
                if (w_odd_push)   r_odd_wp  <= r_odd_wp + PTR_W'(1);
                if (w_grant_even) r_even_rp <= r_even_rp + PTR_W'(1);
                if (w_grant_odd)  r_odd_rp  <= r_odd_rp + PTR_W'(1);
                if (w_rr_flip)    r_rr_odd  <= ~r_rr_odd;
                r_we <= w_grant_even | w_grant_odd;
                if (w_grant_even || w_grant_odd) begin
                    r_waddr <= w_grant_rt;
                    r_wdata <= w_grant_data;
                end
            end
        end
    end

    assign even_ready = r_even_ready;
    assign odd_ready  = r_odd_ready;
    assign rf_we      = r_we;
    assign rf_waddr   = r_waddr;
    assign rf_wdata   = r_wdata;
    assign pending    = r_pending;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: hand-derived vector table, a cycle model feeding a write scoreboard,
// streaming, random flush/same-register traffic, and asynchronous reset mid-stream.
module tb_wb_port_arbiter;

    localparam int DATA_W  = 129;
    localparam int ADDR_W  = 7;
    localparam int DEPTH   = 2;
    localparam int STAMP_W = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              flush = 1'b0;
    logic              even_valid = 1'b0;
    logic [ADDR_W-1:0] even_rt = '0;
    logic [DATA_W-1:0] even_data = '0;
    logic              odd_valid = 1'b0;
    logic [ADDR_W-1:0] odd_rt = '0;
    logic [DATA_W-1:0] odd_data = '0;
    logic              even_ready, odd_ready, rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [2:0]        pending;

    wb_port_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .STAMP_W(STAMP_W)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .even_valid(even_valid), .even_ready(even_ready), .even_rt(even_rt), .even_data(even_data),
        .odd_valid(odd_valid), .odd_ready(odd_ready), .odd_rt(odd_rt), .odd_data(odd_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] rt;
        logic [DATA_W-1:0] data;
        int                seq;
    } ent_t;

    typedef struct {
        bit                ev;
        logic [ADDR_W-1:0] ert;
        logic [DATA_W-1:0] ed;
        bit                ov;
        logic [ADDR_W-1:0] ort;
        logic [DATA_W-1:0] od;
        bit                fl;
        bit                we;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
        logic [2:0]        pend;
        bit                re;
        bit                ro;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    int n_writes = 0;

    // Reference model: arrival order is an unbounded edge count, not a wrapping stamp.
    ent_t              mq_e[$];
    ent_t              mq_o[$];
    ent_t              exp_q[$];
    int                seq = 0;
    bit                m_rr_odd;
    bit                m_ready_e, m_ready_o, m_we;
    logic [ADDR_W-1:0] m_waddr;
    logic [DATA_W-1:0] m_wdata;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq_e.delete();
        mq_o.delete();
        exp_q.delete();
        m_rr_odd  = 1'b0;
        m_ready_e = 1'b0;
        m_ready_o = 1'b0;
        m_we      = 1'b0;
        m_waddr   = '0;
        m_wdata   = '0;
    endtask

    task automatic model_edge();
        ent_t g;
        bit   ge, go;
        ge = 1'b0;
        go = 1'b0;
        g  = '{rt: '0, data: '0, seq: 0};
        if (flush) begin
            mq_e.delete();
            mq_o.delete();
            m_we = 1'b0;
        end else begin
            if (mq_e.size() > 0 && mq_o.size() > 0) begin
                if (mq_e[0].rt == mq_o[0].rt) begin
                    if (mq_e[0].seq <= mq_o[0].seq) ge = 1'b1;
                    else go = 1'b1;
                end else begin
                    if (m_rr_odd) go = 1'b1;
                    else ge = 1'b1;
                    m_rr_odd = !m_rr_odd;
                end
            end else if (mq_e.size() > 0) begin
                ge = 1'b1;
            end else if (mq_o.size() > 0) begin
                go = 1'b1;
            end
            if (ge) g = mq_e.pop_front();
            if (go) g = mq_o.pop_front();
            m_we = ge || go;
            if (m_we) begin
                m_waddr = g.rt;
                m_wdata = g.data;
                exp_q.push_back(g);
            end
            if (even_valid && m_ready_e) mq_e.push_back('{rt: even_rt, data: even_data, seq: seq});
            if (odd_valid && m_ready_o)  mq_o.push_back('{rt: odd_rt, data: odd_data, seq: seq});
        end
        m_ready_e = (mq_e.size() < DEPTH);
        m_ready_o = (mq_o.size() < DEPTH);
        seq++;
    endtask

    task automatic compare_model();
        ent_t e;
        check("rf_we", rf_we, m_we);
        if (rf_we === 1'b1) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_underflow: write to rt %0d with nothing expected", rf_waddr);
            end else begin
                e = exp_q.pop_front();
                check("sb_waddr", rf_waddr, e.rt);
                check("sb_wdata", rf_wdata, e.data);
            end
        end
        check("waddr_hold", rf_waddr, m_waddr);
        check("wdata_hold", rf_wdata, m_wdata);
        check("pending", pending, mq_e.size() + mq_o.size());
        check("even_ready", even_ready, m_ready_e);
        check("odd_ready", odd_ready, m_ready_o);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic idle_inputs();
        even_valid = 1'b0;
        odd_valid  = 1'b0;
        flush      = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl [22];
        bit   acc_e, acc_o, saw_full;
        int   e_n, o_n, pushes, writes_before;

        //        ev ert  ed      ov ort od      fl  we waddr wdata  pend re ro
        tbl[0]  = '{0, 0,  0,      0, 0,  0,      0,  0, 0,  0,      0, 1, 1};
        tbl[1]  = '{1, 5,  'hA,    0, 0,  0,      0,  0, 0,  0,      1, 1, 1};
        tbl[2]  = '{0, 0,  0,      0, 0,  0,      0,  1, 5,  'hA,    0, 1, 1};
        tbl[3]  = '{0, 0,  0,      0, 0,  0,      0,  0, 5,  'hA,    0, 1, 1};
        tbl[4]  = '{1, 9,  1,      1, 9,  2,      0,  0, 5,  'hA,    2, 1, 1};
        tbl[5]  = '{0, 0,  0,      0, 0,  0,      0,  1, 9,  1,      1, 1, 1};
        tbl[6]  = '{0, 0,  0,      0, 0,  0,      0,  1, 9,  2,      0, 1, 1};
        tbl[7]  = '{0, 0,  0,      0, 0,  0,      0,  0, 9,  2,      0, 1, 1};
        tbl[8]  = '{1, 7,  'h71,   1, 7,  'h72,   0,  0, 9,  2,      2, 1, 1};
        tbl[9]  = '{0, 0,  0,      1, 9,  'h99,   0,  1, 7,  'h71,   2, 1, 0};
        tbl[10] = '{1, 9,  'hE9,   0, 0,  0,      0,  1, 7,  'h72,   2, 1, 1};
        tbl[11] = '{0, 0,  0,      0, 0,  0,      0,  1, 9,  'h99,   1, 1, 1};
        tbl[12] = '{0, 0,  0,      0, 0,  0,      0,  1, 9,  'hE9,   0, 1, 1};
        tbl[13] = '{0, 0,  0,      0, 0,  0,      0,  0, 9,  'hE9,   0, 1, 1};
        tbl[14] = '{1, 10, 'hA0,   1, 74, 'hA4,   0,  0, 9,  'hE9,   2, 1, 1};
        tbl[15] = '{1, 11, 'hB0,   1, 75, 'hB4,   0,  1, 10, 'hA0,   3, 1, 0};
        tbl[16] = '{1, 12, 'hC0,   1, 76, 'hC4,   1,  0, 10, 'hA0,   0, 1, 1};
        tbl[17] = '{0, 0,  0,      0, 0,  0,      0,  0, 10, 'hA0,   0, 1, 1};
        tbl[18] = '{1, 20, 'h20,   1, 84, 'h84,   0,  0, 10, 'hA0,   2, 1, 1};
        tbl[19] = '{0, 0,  0,      0, 0,  0,      0,  1, 84, 'h84,   1, 1, 1};
        tbl[20] = '{0, 0,  0,      0, 0,  0,      0,  1, 20, 'h20,   0, 1, 1};
        tbl[21] = '{0, 0,  0,      0, 0,  0,      0,  0, 20, 'h20,   0, 1, 1};

        model_reset();
        #1 reset = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_we", rf_we, 1'b0);
        check("rst_waddr", rf_waddr, 0);
        check("rst_wdata", rf_wdata, 0);
        check("rst_pending", pending, 0);
        check("rst_even_ready", even_ready, 1'b0);
        check("rst_odd_ready", odd_ready, 1'b0);
        reset = 1'b1;

        // Directed table: single write, same-edge ordering, older-first, flush, RR kept across flush.
        for (int i = 0; i < 22; i++) begin
            even_valid = tbl[i].ev;
            even_rt    = tbl[i].ert;
            even_data  = tbl[i].ed;
            odd_valid  = tbl[i].ov;
            odd_rt     = tbl[i].ort;
            odd_data   = tbl[i].od;
            flush      = tbl[i].fl;
            step();
            check($sformatf("v%0d_we", i), rf_we, tbl[i].we);
            check($sformatf("v%0d_waddr", i), rf_waddr, tbl[i].waddr);
            check($sformatf("v%0d_wdata", i), rf_wdata, tbl[i].wdata);
            check($sformatf("v%0d_pending", i), pending, tbl[i].pend);
            check($sformatf("v%0d_even_ready", i), even_ready, tbl[i].re);
            check($sformatf("v%0d_odd_ready", i), odd_ready, tbl[i].ro);
        end
        idle_inputs();

        // Both pipes stream distinct registers; senders hold while not ready.
        e_n = 1;
        o_n = 65;
        pushes = 0;
        saw_full = 1'b0;
        writes_before = n_writes;
        for (int c = 0; c < 40; c++) begin
            even_valid = 1'b1;
            even_rt    = ADDR_W'(e_n);
            even_data  = {1'b1, 64'(e_n), 64'hE0E0};
            odd_valid  = 1'b1;
            odd_rt     = ADDR_W'(o_n);
            odd_data   = {1'b0, 64'(o_n), 64'h0D0D};
            acc_e = m_ready_e;
            acc_o = m_ready_o;
            step();
            if (acc_e) begin e_n++; pushes++; end
            if (acc_o) begin o_n++; pushes++; end
            if (!even_ready || !odd_ready) saw_full = 1'b1;
        end
        idle_inputs();
        for (int c = 0; c < 8; c++) step();
        check("stream_write_count", n_writes - writes_before, pushes);
        check("stream_sb_empty", exp_q.size(), 0);
        check("stream_ready_fell", saw_full, 1'b1);

        // Random traffic on a few colliding registers with occasional flushes.
        for (int c = 0; c < 300; c++) begin
            even_valid = ($urandom_range(0, 3) != 0);
            even_rt    = ADDR_W'($urandom_range(8, 10));
            even_data  = {1'b1, 64'($urandom), 64'(c)};
            odd_valid  = ($urandom_range(0, 3) != 0);
            odd_rt     = ADDR_W'($urandom_range(8, 10));
            odd_data   = {1'b0, 64'($urandom), 64'(c)};
            flush      = ($urandom_range(0, 31) == 0);
            step();
        end
        idle_inputs();
        for (int c = 0; c < 6; c++) step();
        check("random_sb_empty", exp_q.size(), 0);

        // Asynchronous reset between edges while writes are queued.
        even_valid = 1'b1; even_rt = 33; even_data = 'h333;
        odd_valid  = 1'b1; odd_rt  = 97; odd_data  = 'h977;
        step();
        idle_inputs();
        step();
        #2 reset = 1'b0;
        #1;
        check("async_we", rf_we, 1'b0);
        check("async_waddr", rf_waddr, 0);
        check("async_wdata", rf_wdata, 0);
        check("async_pending", pending, 0);
        check("async_even_ready", even_ready, 1'b0);
        check("async_odd_ready", odd_ready, 1'b0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check("held_rst_we", rf_we, 1'b0);
        check("held_rst_even_ready", even_ready, 1'b0);
        reset = 1'b1;
        for (int c = 0; c < 4; c++) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
